// File: rtl/pe_ws_ctrl_pkg.sv
// Shared types and constants for the weight-stationary PE sequencer.
// Holds the FSM state enum, ctrl bus bit indices and perf counter width.
package pe_ws_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PRIME,
    S_COMPUTE,
    S_DRAIN
  } state_t;

  localparam int CTRL_RD_VALID = 0;
  localparam int CTRL_RD_RESET = 1;
  localparam int PERF_WIDTH    = 32;

endpackage

// File: rtl/valid_delay.sv
// Shift register aligning {last, valid} with the PE psum_out pipeline.
// Ports: clk, rst (async active-low), d (input bundle), q (delayed bundle).
module valid_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++)
        sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/pe_ws_ctrl.sv
// Sequencer for one weight-stationary PE: load weights, prime, compute, drain.
// Ports: cfg_*, w_* (weight source), pe_* (PE side), iact_*, psum_*, busy, done.
// Optional PE_WS_CTRL_PERF_EN adds perf_busy_cycles / perf_stall_cycles.
module pe_ws_ctrl
  import pe_ws_ctrl_pkg::*;
#(
  parameter int OP_WIDTH   = 8,
  parameter int CTRL_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int PASS_WIDTH = 16,
  parameter int MAC_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [ADDR_WIDTH-1:0] cfg_klen,
  input  logic [PASS_WIDTH-1:0] cfg_passes,
  input  logic                  cfg_reload,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [OP_WIDTH-1:0]   w_data,
  output logic                  pe_wctrl,
  output logic [OP_WIDTH-1:0]   pe_weight,
  output logic [CTRL_WIDTH-1:0] pe_ctrl,
  input  logic                  iact_valid,
  output logic                  iact_pop,
  output logic                  psum_valid,
  output logic                  psum_last,
  output logic                  busy,
  output logic                  done
`ifdef PE_WS_CTRL_PERF_EN
  ,
  output logic [PERF_WIDTH-1:0] perf_busy_cycles,
  output logic [PERF_WIDTH-1:0] perf_stall_cycles
`endif
);

  localparam int DW = $clog2(MAC_LAT + 1) + 1;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] klen;
  logic [ADDR_WIDTH-1:0] idx;
  logic [PASS_WIDTH-1:0] passes;
  logic [PASS_WIDTH-1:0] pass;
  logic [DW-1:0]         drain_cnt;
  logic                  done_q;

  logic accept;
  logic beat;
  logic step;
  logic idx_end;
  logic last_step;
  logic drain_end;

  assign accept    = cfg_valid && (state == S_IDLE);
  assign beat      = w_valid && (state == S_LOAD);
  assign step      = iact_valid && (state == S_COMPUTE);
  assign idx_end   = (idx == klen);
  assign last_step = step && idx_end && (pass == passes);
  assign drain_end = (state == S_DRAIN) &&
                     (drain_cnt == DW'(MAC_LAT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (accept)
          state_nx = cfg_reload ? S_LOAD : S_PRIME;
      S_LOAD:
        if (beat && idx_end) state_nx = S_PRIME;
      S_PRIME:
        state_nx = S_COMPUTE;
      S_COMPUTE:
        if (last_step) state_nx = S_DRAIN;
      S_DRAIN:
        if (drain_end) state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b0;
    w_ready   = 1'b0;
    pe_wctrl  = 1'b0;
    pe_weight = '0;
    pe_ctrl   = '0;
    iact_pop  = 1'b0;
    busy      = (state != S_IDLE);
    unique case (1'b1)
      (state == S_IDLE): cfg_ready = 1'b1;
      (state == S_LOAD): begin
        w_ready  = 1'b1;
        pe_wctrl = w_valid;
        if (w_valid) pe_weight = w_data;
      end
      (state == S_PRIME): begin
        pe_ctrl[CTRL_RD_VALID] = 1'b1;
        pe_ctrl[CTRL_RD_RESET] = 1'b1;
      end
      (state == S_COMPUTE): begin
        pe_ctrl[CTRL_RD_VALID] = step;
        pe_ctrl[CTRL_RD_RESET] = step && idx_end;
        iact_pop = step;
      end
      default: ;
    endcase
  end

  // idx counts load beats in LOAD and the read position in COMPUTE;
  // the LOAD wrap leaves it at 0 for the first compute step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      klen   <= '0;
      passes <= '0;
      idx    <= '0;
      pass   <= '0;
    end else if (accept) begin
      klen   <= cfg_klen;
      passes <= cfg_passes;
      idx    <= '0;
      pass   <= '0;
    end else if (beat) begin
      idx <= idx_end ? '0 : idx + 1'b1;
    end else if (step) begin
      if (idx_end) begin
        idx  <= '0;
        pass <= pass + 1'b1;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drain_cnt <= '0;
      done_q    <= 1'b0;
    end else begin
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
      done_q    <= drain_end;
    end
  end

  assign done = done_q;

  // One register for the RAM read / iact fetch, MAC_LAT for the MAC.
  valid_delay #(
    .DEPTH (1 + MAC_LAT),
    .WIDTH (2)
  ) u_vd (
    .clk (clk),
    .rst (rst),
    .d   ({step && idx_end, step}),
    .q   ({psum_last, psum_valid})
  );

`ifdef PE_WS_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else if (accept) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (busy && !(&perf_busy_cycles))
        perf_busy_cycles <= perf_busy_cycles + 1'b1;
      if ((state == S_COMPUTE) && !iact_valid &&
          !(&perf_stall_cycles))
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_ws_ctrl.sv
// Scoreboard testbench for pe_ws_ctrl.
// Driver builds expected events per job; a negedge monitor pops and compares.
module tb_pe_ws_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [9:0]  cfg_klen = '0;
  logic [15:0] cfg_passes = '0;
  logic        cfg_reload = 1'b0;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [7:0]  w_data = '0;
  logic        pe_wctrl;
  logic [7:0]  pe_weight;
  logic [7:0]  pe_ctrl;
  logic        iact_valid = 1'b0;
  logic        iact_pop;
  logic        psum_valid;
  logic        psum_last;
  logic        busy;
  logic        done;

  pe_ws_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_klen   (cfg_klen),
    .cfg_passes (cfg_passes),
    .cfg_reload (cfg_reload),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_data     (w_data),
    .pe_wctrl   (pe_wctrl),
    .pe_weight  (pe_weight),
    .pe_ctrl    (pe_ctrl),
    .iact_valid (iact_valid),
    .iact_pop   (iact_pop),
    .psum_valid (psum_valid),
    .psum_last  (psum_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    bit [7:0] v;
    bit       b;
  } rec_t;

  rec_t cq[$];
  rec_t wq[$];
  rec_t pq[$];
  rec_t dq[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    w_valid    = 1'($urandom_range(0, 1));
    iact_valid = 1'($urandom_range(0, 1));
    w_data     = 8'($urandom);
    cfg_klen   = 10'($urandom);
    cfg_passes = 16'($urandom);
    cfg_reload = 1'($urandom_range(0, 1));
  endtask

  // im/wm: 0 = always high, 1 = random, 2 = pattern (toggle / every third)
  task automatic job(int k, int p, bit rl, int im, int wm);
    int b, n, s;
    bit lst;
    noise();
    cfg_valid  = 1'b1;
    cfg_klen   = 10'(k - 1);
    cfg_passes = 16'(p - 1);
    cfg_reload = rl;
    next();
    cfg_valid = 1'b0;
    if (rl) begin
      b = 0;
      n = 0;
      while (b < k) begin
        noise();
        w_valid = (wm == 0) ? 1'b1 :
                  (wm == 1) ? 1'($urandom_range(0, 1)) :
                  ((n % 3) == 0);
        if (w_valid) begin
          wq.push_back('{cyc, w_data, 1'b0});
          b++;
        end
        n++;
        next();
      end
    end
    noise();
    cq.push_back('{cyc, 8'h03, 1'b0});
    next();
    s = 0;
    n = 0;
    while (s < k * p) begin
      noise();
      iact_valid = (im == 0) ? 1'b1 :
                   (im == 1) ? 1'($urandom_range(0, 1)) :
                   ((n % 2) == 0);
      if (iact_valid) begin
        lst = ((s % k) == k - 1);
        cq.push_back('{cyc, lst ? 8'h03 : 8'h01, 1'b1});
        pq.push_back('{cyc + 2, 8'h00, lst});
        s++;
      end
      n++;
      next();
    end
    noise();
    next();
    noise();
    next();
    dq.push_back('{cyc, 8'h00, 1'b0});
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      noise();
      next();
    end
  endtask

  always @(negedge clk) begin
    rec_t r;
    if (rst) begin
      if (pe_ctrl != 0 || iact_pop) begin
        if (cq.size() == 0) chk("ctrl_unexpected", cyc, -1);
        else begin
          r = cq.pop_front();
          chk("ctrl_cycle", cyc, r.cyc);
          chk("ctrl_value", pe_ctrl, r.v);
          chk("ctrl_pop", iact_pop, r.b);
        end
      end
      if (pe_wctrl) begin
        if (wq.size() == 0) chk("wctrl_unexpected", cyc, -1);
        else begin
          r = wq.pop_front();
          chk("wctrl_cycle", cyc, r.cyc);
          chk("weight_data", pe_weight, r.v);
          chk("w_ready", w_ready, 1);
        end
      end else begin
        chk("weight_zero", pe_weight, 0);
      end
      if (psum_valid) begin
        if (pq.size() == 0) chk("psum_unexpected", cyc, -1);
        else begin
          r = pq.pop_front();
          chk("psum_cycle", cyc, r.cyc);
          chk("psum_last", psum_last, r.b);
        end
      end
      if (done) begin
        if (dq.size() == 0) chk("done_unexpected", cyc, -1);
        else begin
          r = dq.pop_front();
          chk("done_cycle", cyc, r.cyc);
          chk("done_cfg_ready", cfg_ready, 1);
        end
      end
    end
  end

  initial begin
    #12;
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pe_ctrl", pe_ctrl, 0);
    chk("rst_psum_valid", psum_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_w_ready", w_ready, 0);
    next();
    rst = 1'b1;
    idle(2);

    job(4, 2, 1'b1, 0, 0);
    idle(3);
    job(4, 2, 1'b0, 0, 0);
    idle(2);
    job(4, 2, 1'b0, 2, 0);
    job(1, 3, 1'b1, 0, 0);
    idle(1);
    job(5, 2, 1'b1, 1, 2);
    idle(2);

    // reset in the middle of COMPUTE
    noise();
    cfg_valid  = 1'b1;
    cfg_klen   = 10'd3;
    cfg_passes = 16'd1;
    cfg_reload = 1'b0;
    next();
    cfg_valid = 1'b0;
    noise();
    cq.push_back('{cyc, 8'h03, 1'b0});
    next();
    for (int i = 0; i < 3; i++) begin
      noise();
      iact_valid = 1'b1;
      cq.push_back('{cyc, 8'h01, 1'b1});
      pq.push_back('{cyc + 2, 8'h00, 1'b0});
      next();
    end
    noise();
    iact_valid = 1'b0;
    w_valid    = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_cfg_ready", cfg_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pe_ctrl", pe_ctrl, 0);
    chk("mid_rst_iact_pop", iact_pop, 0);
    chk("mid_rst_psum_valid", psum_valid, 0);
    chk("mid_rst_done", done, 0);
    pq.delete();
    next();
    rst = 1'b1;
    idle(1);
    job(4, 2, 1'b0, 0, 0);
    idle(2);

    for (int j = 0; j < 10; j++) begin
      job($urandom_range(1, 6), $urandom_range(1, 3),
          1'($urandom_range(0, 1)), 1, 1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(6);

    chk("ctrl_queue_left", cq.size(), 0);
    chk("weight_queue_left", wq.size(), 0);
    chk("psum_queue_left", pq.size(), 0);
    chk("done_queue_left", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
